find_peaks_k: RTL
=================

# find_peaks_k

Streaming top-K local-peak finder: the parametrised successor to the single-maximum finder. Accepts one frame of unsigned samples on an address-tagged AXI-Stream-style slave port and detects local maxima over a 3-sample window. It keeps the NUM_PEAKS largest peaks at or above a runtime threshold, sorted descending, then emits them one per beat on the master port, each with its left/centre/right samples for downstream sub-bin interpolation. Sits between the spectrum/magnitude stage and the interpolation/frequency-estimate logic.

## Interface
- DATA_WIDTH, 8, sample width (unsigned)
- ADDR_WIDTH, 6, sample address width
- NUM_PEAKS, 3, K peaks retained per frame (≥1)
- RANK_WIDTH, 2, width of rank output; must satisfy 2^RANK_WIDTH ≥ NUM_PEAKS
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- threshold  in  DATA_WIDTH  minimum peak value; sampled at each candidate evaluation
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  last sample of frame
- s_axis_tdata  in  DATA_WIDTH  sample
- s_axis_taddr  in  ADDR_WIDTH  sample address
- s_axis_tready  out  1  high in ACCEPT state and rst low
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  result beat valid
- m_axis_tlast  out  1  high on rank NUM_PEAKS-1 beat
- m_axis_tdata_l / _c / _r  out  DATA_WIDTH each  left, centre (peak), right samples
- m_axis_taddr  out  ADDR_WIDTH  address of centre sample
- m_axis_trank  out  RANK_WIDTH  0 = largest
- m_axis_tfound  out  1  slot holds a real peak; 0 means slot is empty and its data/addr are 0

## Operation
- Input beat accepted when s_axis_tvalid && s_axis_tready. tvalid gaps are allowed; the window advances only on accepted beats.
- Window registers: left (prev1), cand (prev0, with its addr), and a per-frame sample count saturating at 2.
- On each accepted beat with count==2, evaluate cand using right = current tdata. Peak iff cand > left && cand >= right && cand >= threshold.
  - The plateau rule reports the first sample of a flat top only.
  - First and last samples of a frame are never peaks, because they lack a neighbour.
- Peak list: NUM_PEAKS slots {found, l, c, r, addr}, sorted descending by c.
  - Insertion is a single-cycle parallel compare/shift.
  - A new peak is placed below all existing slots with c ≥ its value, so ties keep the earlier address at the higher rank.
  - The lowest slot drops out when the list is full.
  - A peak smaller than every full slot is discarded.
- FSM has two states.
  - ACCEPT (reset state): collect samples. An accepted beat with tlast performs its final evaluation, then the FSM moves to OUTPUT.
  - OUTPUT: s_axis_tready=0. Slots are presented in rank order 0..NUM_PEAKS-1, advancing on m_axis_tvalid && m_axis_tready.
  - After the rank NUM_PEAKS-1 beat is accepted: clear the list, window and count, and return to ACCEPT.
- Always exactly NUM_PEAKS output beats per frame, including when no peaks are found (all tfound=0).
- Frame length 1 or 2: no peaks, NUM_PEAKS empty beats.
- All comparisons are unsigned, with no arithmetic growth.

## Timing
- Reset values: state=ACCEPT, s_axis_tready=0 while rst is high and 1 from the first cycle after; m_axis_tvalid=0, m_axis_tlast=0; all data, addr, rank, found and list slots = 0.
- rst mid-frame or mid-output: the frame is discarded, with no partial output. Next frame starts clean.
- Latency: the tlast beat is accepted at edge N, and rank 0 is valid in the cycle after edge N (m_axis_tvalid=1).
- With m_axis_tready held high, rank k is presented in cycle N+1+k. s_axis_tready returns to 1 in cycle N+1+NUM_PEAKS.
- Master outputs stay stable while m_axis_tvalid && !m_axis_tready.
- s_axis_tready is 0 for the entire OUTPUT state. Input beats presented then are not consumed.
- Result outputs are registered from the slot array indexed by rank counter, with no combinational path from s_axis_* to m_axis_*.

## Test plan
- Frame 1,2,3,4,5,4,3,2,1,2 (addr 0–9), K=3, threshold=0 -> rank0 found=1 addr=4 l/c/r=4/5/4; ranks 1,2 found=0, all data 0; tlast on rank2; last sample 2 is not a peak.
- Frame 0,7,0,9,0,3,0,9,0, threshold=0 -> 9@3 (0/9/0), 9@7 (0/9/0), 7@1 (0/7/0); 3@5 dropped.
- Same frame, threshold=8 -> 9@3, 9@7, rank2 found=0.
- Frame 1,5,5,1 -> single peak addr=1 l/c/r=1/5/5; addr 2 is not reported. Frame 9,1,2 -> no peaks (edge rule).
- Backpressure: hold m_axis_tready=0 for 4 cycles at rank1 -> outputs frozen, s_axis_tready=0 throughout; tvalid gaps in input give results identical to the gapless run.
- Assert rst for one cycle mid-frame, then send the frame 0,7,0,9,0,3,0,9,0 -> no output for the aborted frame; the new frame output matches the second scenario exactly.

Source files
------------

// File: rtl/find_peaks_k.sv
// +----------------------------------------------------------------------------+
// | find_peaks_k: streaming 3-sample local-peak finder keeping the top-K peaks  |
// | of a frame, emitted sorted one per beat.            Rev 1.0                |
// +----------------------------------------------------------------------------+
`default_nettype none

module find_peaks_k #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_PEAKS  = 3,
  parameter int RANK_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [ADDR_WIDTH-1:0] s_axis_taddr,
  output logic                  s_axis_tready,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_l,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_c,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_r,
  output logic [ADDR_WIDTH-1:0] m_axis_taddr,
  output logic [RANK_WIDTH-1:0] m_axis_trank,
  output logic                  m_axis_tfound
);

  typedef enum logic [0:0] {
    ST_ACCEPT = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  localparam logic [RANK_WIDTH-1:0] c_LAST_RANK = RANK_WIDTH'(NUM_PEAKS - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_cand;
  logic [ADDR_WIDTH-1:0] r_cand_addr;
  logic [1:0]            r_cnt;

  logic                  r_found [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] r_l     [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] r_c     [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] r_r     [NUM_PEAKS];
  logic [ADDR_WIDTH-1:0] r_addr  [NUM_PEAKS];

  logic                  w_found [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] w_l     [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] w_c     [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] w_r     [NUM_PEAKS];
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_PEAKS];

  logic                  w_pv_found [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] w_pv_l     [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] w_pv_c     [NUM_PEAKS];
  logic [DATA_WIDTH-1:0] w_pv_r     [NUM_PEAKS];
  logic [ADDR_WIDTH-1:0] w_pv_addr  [NUM_PEAKS];

  logic [NUM_PEAKS-1:0]  w_ge;
  logic [NUM_PEAKS-1:0]  w_above;
  logic                  w_acc;
  logic                  w_ins;
  logic                  w_clear;
  logic [RANK_WIDTH-1:0] w_rank_nxt;

  assign s_axis_tready = (r_state == ST_ACCEPT) && !rst;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_ins         = w_acc && (r_cnt == 2'd2) && (r_cand > r_left) &&
                         (r_cand >= s_axis_tdata) && (r_cand >= threshold);
  assign w_clear       = rst || ((r_state == ST_OUTPUT) && m_axis_tready &&
                                 (m_axis_trank == c_LAST_RANK));
  assign w_rank_nxt    = m_axis_trank + 1'b1;

  // Slots with c >= new value stay put; the first slot below them takes the
  // new peak and everything further down shifts one place.
  for (genvar i = 0; i < NUM_PEAKS; i++) begin : g_slot
    assign w_ge[i] = r_found[i] && (r_c[i] >= r_cand);
    if (i == 0) begin : g_head
      assign w_above[i]    = 1'b1;
      assign w_pv_found[i] = 1'b0;
      assign w_pv_l[i]     = '0;
      assign w_pv_c[i]     = '0;
      assign w_pv_r[i]     = '0;
      assign w_pv_addr[i]  = '0;
    end else begin : g_tail
      assign w_above[i]    = w_ge[i-1];
      assign w_pv_found[i] = r_found[i-1];
      assign w_pv_l[i]     = r_l[i-1];
      assign w_pv_c[i]     = r_c[i-1];
      assign w_pv_r[i]     = r_r[i-1];
      assign w_pv_addr[i]  = r_addr[i-1];
    end
    assign w_found[i] = (!w_ins || w_ge[i]) ? r_found[i] : (w_above[i] ? 1'b1 : w_pv_found[i]);
    assign w_l[i]     = (!w_ins || w_ge[i]) ? r_l[i]     : (w_above[i] ? r_left : w_pv_l[i]);
    assign w_c[i]     = (!w_ins || w_ge[i]) ? r_c[i]     : (w_above[i] ? r_cand : w_pv_c[i]);
    assign w_r[i]     = (!w_ins || w_ge[i]) ? r_r[i]     : (w_above[i] ? s_axis_tdata : w_pv_r[i]);
    assign w_addr[i]  = (!w_ins || w_ge[i]) ? r_addr[i]  : (w_above[i] ? r_cand_addr : w_pv_addr[i]);
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state        <= ST_ACCEPT;
      r_left         <= '0;
      r_cand         <= '0;
      r_cand_addr    <= '0;
      r_cnt          <= 2'd0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tfound  <= 1'b0;
      m_axis_tdata_l <= '0;
      m_axis_tdata_c <= '0;
      m_axis_tdata_r <= '0;
      m_axis_taddr   <= '0;
      m_axis_trank   <= '0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        r_found[i] <= 1'b0;
        r_l[i]     <= '0;
        r_c[i]     <= '0;
        r_r[i]     <= '0;
        r_addr[i]  <= '0;
      end
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_acc) begin
            r_left      <= r_cand;
            r_cand      <= s_axis_tdata;
            r_cand_addr <= s_axis_taddr;
            if (r_cnt != 2'd2) r_cnt <= r_cnt + 2'd1;
            for (int i = 0; i < NUM_PEAKS; i++) begin
              r_found[i] <= w_found[i];
              r_l[i]     <= w_l[i];
              r_c[i]     <= w_c[i];
              r_r[i]     <= w_r[i];
              r_addr[i]  <= w_addr[i];
            end
            // Rank 0 is loaded from the post-insertion list so the final
            // evaluation is visible on the very next cycle.
            if (s_axis_tlast) begin
              r_state        <= ST_OUTPUT;
              m_axis_tvalid  <= 1'b1;
              m_axis_tlast   <= (c_LAST_RANK == '0);
              m_axis_trank   <= '0;
              m_axis_tfound  <= w_found[0];
              m_axis_tdata_l <= w_l[0];
              m_axis_tdata_c <= w_c[0];
              m_axis_tdata_r <= w_r[0];
              m_axis_taddr   <= w_addr[0];
            end
          end
        end
        ST_OUTPUT: begin
          if (m_axis_tready) begin
            m_axis_trank   <= w_rank_nxt;
            m_axis_tlast   <= (w_rank_nxt == c_LAST_RANK);
            m_axis_tfound  <= r_found[w_rank_nxt];
            m_axis_tdata_l <= r_l[w_rank_nxt];
            m_axis_tdata_c <= r_c[w_rank_nxt];
            m_axis_tdata_r <= r_r[w_rank_nxt];
            m_axis_taddr   <= r_addr[w_rank_nxt];
          end
        end
        default: r_state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

`default_nettype wire
